// File: rtl/seg_capture.sv
// Segment-bus receiver: qualifies a 7-bit glyph by stability, decodes it to hex, counts updates.
// Optional sequence checking is compiled in with SEG_CAPTURE_SEQ_CHECK_EN.
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [3:0]       hex_o,
  output logic             valid_o,
  output logic             bad_o,
  output logic [CNT_W-1:0] upd_cnt_o,
  output logic             seq_err_o
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 15) begin : g_bad_stable
    $error("seg_capture: STABLE_CYCLES must be in 1..15");
  end

  localparam logic [3:0] STABLE_L = 4'(STABLE_CYCLES);

  logic [6:0]       smp_q, smp_d;
  logic [3:0]       run_q, run_d;
  logic [6:0]       acc_q, acc_d;
  logic             acc_v_q, acc_v_d;
  logic [3:0]       hex_q, hex_d;
  logic             valid_q, valid_d;
  logic             bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_hex;
  logic       dec_bad;
  logic       accept;

  always_comb begin
    dec_hex = 4'h0;
    dec_bad = 1'b0;
    case (seg_in)
      7'h3F: dec_hex = 4'h0;
      7'h06: dec_hex = 4'h1;
      7'h5B: dec_hex = 4'h2;
      7'h4F: dec_hex = 4'h3;
      7'h66: dec_hex = 4'h4;
      7'h6D: dec_hex = 4'h5;
      7'h7D: dec_hex = 4'h6;
      7'h07: dec_hex = 4'h7;
      7'h7F: dec_hex = 4'h8;
      7'h6F: dec_hex = 4'h9;
      7'h77: dec_hex = 4'hA;
      7'h7C: dec_hex = 4'hB;
      7'h39: dec_hex = 4'hC;
      7'h5E: dec_hex = 4'hD;
      7'h79: dec_hex = 4'hE;
      7'h71: dec_hex = 4'hF;
      default: dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    smp_d   = seg_in;
    acc_d   = acc_q;
    acc_v_d = acc_v_q;
    hex_d   = hex_q;
    valid_d = 1'b0;
    bad_d   = bad_q;
    cnt_d   = cnt_q;

    // Run length saturates so a long-held pattern never wraps back into acceptance.
    if (seg_in == smp_q) begin
      run_d = (run_q >= STABLE_L) ? STABLE_L : run_q + 4'd1;
    end else begin
      run_d = 4'd1;
    end

    accept = (run_d == STABLE_L) && (!acc_v_q || (seg_in != acc_q));

    if (accept) begin
      acc_d   = seg_in;
      acc_v_d = 1'b1;
      valid_d = 1'b1;
      hex_d   = dec_hex;
      bad_d   = dec_bad;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q   <= '0;
      run_q   <= '0;
      acc_q   <= '0;
      acc_v_q <= 1'b0;
      hex_q   <= '0;
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      smp_q   <= smp_d;
      run_q   <= run_d;
      acc_q   <= acc_d;
      acc_v_q <= acc_v_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEG_CAPTURE_SEQ_CHECK_EN
  logic seq_err_q, seq_err_d;

  // hex_q/bad_q still describe the previous accept when the new one is evaluated.
  always_comb begin
    seq_err_d = seq_err_q;
    if (accept && acc_v_q) begin
      if (dec_bad || (!bad_q && (dec_hex != hex_q + 4'd1))) begin
        seq_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err_o = seq_err_q;
`else
  assign seq_err_o = 1'b0;
`endif

  assign hex_o     = hex_q;
  assign valid_o   = valid_q;
  assign bad_o     = bad_q;
  assign upd_cnt_o = cnt_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture with default parameters (STABLE_CYCLES=3, CNT_W=8).
module tb_seg_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_in = 7'h00;
  logic [3:0] hex_o;
  logic       valid_o;
  logic       bad_o;
  logic [7:0] upd_cnt_o;
  logic       seq_err_o;

  int vectors = 0;
  int miscompares = 0;
  int pulses;

`ifdef SEG_CAPTURE_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  seg_capture #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .hex_o     (hex_o),
    .valid_o   (valid_o),
    .bad_o     (bad_o),
    .upd_cnt_o (upd_cnt_o),
    .seq_err_o (seq_err_o)
  );

  always #5 clk = ~clk;

  // Present a pattern for one rising edge, then settle before any check.
  task automatic tick(input logic [6:0] p);
    seg_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    $display("[%0t] %s observed=%0h expected=%0h", $time, tag, obs, exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(7'h00);
    tick(7'h00);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".hex"}, 32'(hex_o), 32'h0);
    chk({tag, ".valid"}, 32'(valid_o), 32'h0);
    chk({tag, ".bad"}, 32'(bad_o), 32'h0);
    chk({tag, ".cnt"}, 32'(upd_cnt_o), 32'h0);
    chk({tag, ".seq"}, 32'(seq_err_o), 32'h0);
  endtask

  initial begin
    logic [6:0] glyph [0:16];
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3F};

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // 06 held: accept on the third sampling edge, single-cycle pulse
    tick(7'h06); chk("hold1.valid", 32'(valid_o), 32'h0);
    tick(7'h06); chk("hold2.valid", 32'(valid_o), 32'h0);
    tick(7'h06);
    chk("hold3.valid", 32'(valid_o), 32'h1);
    chk("hold3.hex", 32'(hex_o), 32'h1);
    chk("hold3.bad", 32'(bad_o), 32'h0);
    chk("hold3.cnt", 32'(upd_cnt_o), 32'h1);
    tick(7'h06);
    chk("hold4.valid", 32'(valid_o), 32'h0);
    chk("hold4.cnt", 32'(upd_cnt_o), 32'h1);

    // Glitch breaks the run
    do_reset();
    pulses = 0;
    tick(7'h06); pulses += int'(valid_o);
    tick(7'h06); pulses += int'(valid_o);
    tick(7'h5B); pulses += int'(valid_o);
    tick(7'h06); pulses += int'(valid_o);
    tick(7'h06); pulses += int'(valid_o);
    chk("glitch.no_accept", 32'(pulses), 32'h0);
    tick(7'h06);
    chk("glitch.valid", 32'(valid_o), 32'h1);
    chk("glitch.hex", 32'(hex_o), 32'h1);
    chk("glitch.cnt", 32'(upd_cnt_o), 32'h1);

    // 4F accepted, then held 20 more cycles with no re-accept
    tick(7'h4F); tick(7'h4F); tick(7'h4F);
    chk("4f.valid", 32'(valid_o), 32'h1);
    chk("4f.hex", 32'(hex_o), 32'h3);
    chk("4f.cnt", 32'(upd_cnt_o), 32'h2);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick(7'h4F);
      pulses += int'(valid_o);
    end
    chk("4f_hold.pulses", 32'(pulses), 32'h0);
    chk("4f_hold.cnt", 32'(upd_cnt_o), 32'h2);

    // Full glyph sweep 0..F then 0, each held 4 cycles
    do_reset();
    pulses = 0;
    for (int g = 0; g < 17; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick(glyph[g]);
        pulses += int'(valid_o);
        if (c == 2) begin
          chk($sformatf("sweep%0d.valid", g), 32'(valid_o), 32'h1);
          chk($sformatf("sweep%0d.hex", g), 32'(hex_o), 32'(g % 16));
        end
      end
    end
    chk("sweep.pulses", 32'(pulses), 32'd17);
    chk("sweep.cnt", 32'(upd_cnt_o), 32'd17);
    chk("sweep.seq", 32'(seq_err_o), 32'h0);
    chk("sweep.bad", 32'(bad_o), 32'h0);

    // 4 then 8 breaks the sequence; then an illegal pattern
    do_reset();
    for (int c = 0; c < 4; c++) tick(7'h66);
    chk("seq4.hex", 32'(hex_o), 32'h4);
    chk("seq4.seq", 32'(seq_err_o), 32'h0);
    for (int c = 0; c < 4; c++) tick(7'h7F);
    chk("seq8.hex", 32'(hex_o), 32'h8);
    chk("seq8.seq", 32'(seq_err_o), 32'(SEQ_EXP));
    tick(7'h01); tick(7'h01); tick(7'h01);
    chk("illegal.valid", 32'(valid_o), 32'h1);
    chk("illegal.hex", 32'(hex_o), 32'h0);
    chk("illegal.bad", 32'(bad_o), 32'h1);
    chk("illegal.cnt", 32'(upd_cnt_o), 32'h3);
    chk("illegal.seq", 32'(seq_err_o), 32'(SEQ_EXP));

    // Illegal back to legal clears bad_o
    tick(7'h5B); tick(7'h5B); tick(7'h5B);
    chk("relegal.hex", 32'(hex_o), 32'h2);
    chk("relegal.bad", 32'(bad_o), 32'h0);
    chk("relegal.cnt", 32'(upd_cnt_o), 32'h4);

    // Reset mid-qualification discards the partial run
    tick(7'h6D); tick(7'h6D);
    reset = 1'b1;
    tick(7'h6D);
    chk_all_zero("midreset");
    reset = 1'b0;
    pulses = 0;
    tick(7'h6D); pulses += int'(valid_o);
    tick(7'h6D); pulses += int'(valid_o);
    chk("midreset.early", 32'(pulses), 32'h0);
    tick(7'h6D);
    chk("midreset.valid", 32'(valid_o), 32'h1);
    chk("midreset.hex", 32'(hex_o), 32'h5);
    chk("midreset.cnt", 32'(upd_cnt_o), 32'h1);
    chk("midreset.seq", 32'(seq_err_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
